// File: rtl/data_pack_serializer.sv
// data_pack_serializer: FIFO-buffered 4-bit pack to LSB-first serial bit stream; DATA_PACK_PARITY_EN adds an even-parity bit per pack
module data_pack_serializer #(
  parameter int DEPTH  = 4,
  parameter int PACK_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PACK_W-1:0] pack_in,
  input  logic              pack_valid,
  output logic              pack_ready,
  output logic              bit_out,
  output logic              en_out,
  input  logic              tx_ready,
  output logic              pack_done,
  output logic              busy
);
  localparam int AW = $clog2(DEPTH);
`ifdef DATA_PACK_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  logic                par_q;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t              state_q;
  logic [PACK_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [AW:0]         level_q, level_d;
  logic [PACK_W-1:0]   shreg_q, head;
  logic [1:0]          bitcnt_q;
  logic                pack_done_q;
  logic                empty, full, push, pop, last_bit, word_end;
  assign empty      = level_q == '0;
  assign full       = level_q == (AW+1)'(DEPTH);
  assign pack_ready = !full;
  assign push       = pack_valid && !full;
  assign head       = mem_q[rd_ptr_q];
  assign last_bit   = state_q == SHIFT && tx_ready && bitcnt_q == 2'd3;
`ifdef DATA_PACK_PARITY_EN
  assign word_end   = state_q == PAR && tx_ready;
  assign bit_out    = state_q == SHIFT ? shreg_q[0] : state_q == PAR ? par_q : 1'b0;
`else
  assign word_end   = last_bit;
  assign bit_out    = state_q == SHIFT ? shreg_q[0] : 1'b0;
`endif
  assign pop        = !empty && (state_q == IDLE || word_end);
  assign en_out     = state_q != IDLE;
  assign pack_done  = pack_done_q;
  assign busy       = !empty || state_q != IDLE;
  // Next FIFO occupancy; a same-cycle push and pop cancel out
  always_comb begin
    level_d = push && !pop ? level_q + 1'b1 : pop && !push ? level_q - 1'b1 : level_q;
  end
  // Pack storage, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pack_in;
  end
  // FIFO pointers and level; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_q  <= level_d;
    end
  end
  // Shifter FSM: load from FIFO, shift on tx_ready, reload back-to-back at pack end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bitcnt_q    <= '0;
      pack_done_q <= 1'b0;
`ifdef DATA_PACK_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      pack_done_q <= word_end;
      case (state_q)
        SHIFT: begin
          if (tx_ready) begin
            shreg_q  <= shreg_q >> 1;
            bitcnt_q <= bitcnt_q + 2'd1;
          end
`ifdef DATA_PACK_PARITY_EN
          if (last_bit) state_q <= PAR;
`else
          if (last_bit) state_q <= empty ? IDLE : SHIFT;
`endif
        end
`ifdef DATA_PACK_PARITY_EN
        PAR: if (tx_ready) state_q <= empty ? IDLE : SHIFT;
`endif
        default: state_q <= empty ? IDLE : SHIFT;
      endcase
      if (pop) begin
        shreg_q  <= head;
        bitcnt_q <= '0;
`ifdef DATA_PACK_PARITY_EN
        par_q    <= ^head;
`endif
      end
    end
  end
endmodule
